// File: rtl/mem_access_pkg.sv
// Shared encodings for the core-to-memory initiator and its lane aligner.
package mem_access_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam logic [3:0] WMASK_B = 4'h1;
  localparam logic [3:0] WMASK_H = 4'h3;
  localparam logic [3:0] WMASK_W = 4'hF;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } mreq_t;

  // Illegal size always errors; alignment only matters when checking is enabled.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off,
                                      input logic chk_align);
    logic mis;
    mis = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'd0));
    return (size == SZ_X) || (chk_align && mis);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shift/mask and load extract/extend. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [31:0] w_rsh;

  assign w_sh  = {i_off, 3'b000};
  assign w_rsh = i_rdata >> w_sh;

  // Store side: data moves up by the byte offset; mask bits past lane 3 fall off.
  always_comb begin
    o_wdata = i_wdata << w_sh;
    o_wmask = 4'h0;
    case (i_size)
      SZ_B:    o_wmask = WMASK_B << i_off;
      SZ_H:    o_wmask = WMASK_H << i_off;
      SZ_W:    o_wmask = WMASK_W;
      default: o_wmask = 4'h0;
    endcase
  end

  // Load side: bring the addressed lane down, then zero- or sign-extend.
  always_comb begin
    o_rdata = 32'h0;
    case (i_size)
      SZ_B:    o_rdata = {{24{i_signed & w_rsh[7]}},  w_rsh[7:0]};
      SZ_H:    o_rdata = {{16{i_signed & w_rsh[15]}}, w_rsh[15:0]};
      SZ_W:    o_rdata = w_rsh;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Core-to-memory initiator: one outstanding load/store, word-aligned memory port.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      r_state, w_state_nxt;
  mreq_t       r_req;
  logic [3:0]  r_cnt;
  logic        r_first;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_err;
  logic        w_in_access;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_mask;
  logic [31:0] w_ld_data;

  assign w_err       = req_is_err(req_size, req_addr[1:0], CHECK_ALIGN);
  assign w_in_access = (r_state == ACCESS);

  mem_lane_align u_align (
    .i_off    (r_req.addr[1:0]),
    .i_size   (r_req.size),
    .i_signed (r_req.sgn),
    .i_wdata  (r_req.wdata),
    .i_rdata  (mem_rdata),
    .o_wdata  (w_st_data),
    .o_wmask  (w_st_mask),
    .o_rdata  (w_ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request latch, latency counter and captured load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= '0;
      r_cnt   <= 4'd0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else if (w_accept) begin
      r_req   <= '{wen: req_wen, addr: req_addr, wdata: req_wdata,
                   size: req_size, sgn: req_signed};
      r_cnt   <= LAT_M1;
      r_first <= 1'b1;
      r_err   <= w_err;
      r_rdata <= 32'h0;
    end else if (w_in_access) begin
      r_first <= 1'b0;
      if (r_cnt != 4'd0)   r_cnt   <= r_cnt - 4'd1;
      else if (!r_req.wen) r_rdata <= w_ld_data;
    end
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_valid   = 1'b0;
    mem_wen     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_valid = 1'b1;
        // Single write strobe so the responder commits the store exactly once.
        mem_wen   = r_req.wen & r_first;
        if (r_cnt == 4'd0) w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address/data busses are only non-zero while an access is in flight.
  assign mem_raddr  = w_in_access ? {r_req.addr[31:2], 2'b00} : 32'h0;
  assign mem_waddr  = w_in_access ? {r_req.addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = w_in_access ? w_st_data : 32'h0;
  assign mem_wmask  = w_in_access ? {4'h0, w_st_mask} : 8'h0;
  assign resp_rdata = (r_state == RESP) ? r_rdata : 32'h0;
  assign resp_err   = (r_state == RESP) & r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=3.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid[2], req_ready[2], req_wen[2], req_signed[2];
  logic [31:0] req_addr[2], req_wdata[2];
  logic [1:0]  req_size[2];
  logic        resp_valid[2], resp_ready[2], resp_err[2];
  logic [31:0] resp_rdata[2];
  logic        mem_valid[2], mem_wen[2];
  logic [31:0] mem_raddr[2], mem_waddr[2], mem_wdata[2], mem_rdata[2];
  logic [7:0]  mem_wmask[2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(.MEM_LAT(g == 0 ? 1 : 3), .CHECK_ALIGN(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wen(req_wen[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_size(req_size[g]),
      .req_signed(req_signed[g]), .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .mem_valid(mem_valid[g]),
      .mem_wen(mem_wen[g]), .mem_raddr(mem_raddr[g]), .mem_waddr(mem_waddr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] sz,
                                           input logic sgn, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = addr[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    return (sgn && b[7]) ? {24'hFF_FFFF, b} : {24'h0, b};
      2'd1:    return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [7:0] exp_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0: case (off)
              2'd0: return 8'h01;
              2'd1: return 8'h02;
              2'd2: return 8'h04;
              default: return 8'h08;
            endcase
      2'd1:    return off[1] ? 8'h0C : 8'h03;
      default: return 8'h0F;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] off);
    case (off)
      2'd0:    return wd;
      2'd1:    return {wd[23:0], 8'h0};
      2'd2:    return {wd[15:0], 16'h0};
      default: return {wd[7:0], 24'h0};
    endcase
  endfunction

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, "_resp_err"},   32'(resp_err[d]),   32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata[d],      32'd0);
    chk({tag, "_mem_valid"},  32'(mem_valid[d]),  32'd0);
    chk({tag, "_mem_wen"},    32'(mem_wen[d]),    32'd0);
    chk({tag, "_raddr"},      mem_raddr[d],       32'd0);
    chk({tag, "_waddr"},      mem_waddr[d],       32'd0);
    chk({tag, "_wdata"},      mem_wdata[d],       32'd0);
    chk({tag, "_wmask"},      32'(mem_wmask[d]),  32'd0);
  endtask

  // One full transaction. stall = cycles resp_ready is held low once resp_valid shows.
  // chain = during the stall, raise a follow-up word load to 0x8000_0010 and keep it up.
  // pre = request inputs already held from a previous chain; start on this negedge.
  task automatic do_req(input int d, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] rd, input int stall, input bit pre, input bit chain);
    int    lat, nmv, nwen, rv_cyc, mv_first;
    logic  err;
    bit    done;
    resp_t e;
    lat     = (d == 0) ? 1 : 3;
    err     = exp_err(sz, addr[1:0]);
    e.err   = err;
    e.rdata = (err || wen) ? 32'h0 : exp_load(addr, sz, sgn, rd);
    sb_q.push_back(e);
    if (!pre) @(negedge clk);
    chk("rdy_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wd;
    req_size[d] = sz; req_signed[d] = sgn; mem_rdata[d] = rd; resp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    nmv = 0; nwen = 0; rv_cyc = 0; mv_first = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_valid[d]) begin
        nmv++;
        if (mem_wen[d]) nwen++;
        if (mv_first == 0) begin
          mv_first = c;
          chk("raddr", mem_raddr[d], {addr[31:2], 2'b00});
          chk("waddr", mem_waddr[d], {addr[31:2], 2'b00});
          if (wen) begin
            chk("wmask", 32'(mem_wmask[d]), 32'(exp_mask(sz, addr[1:0])));
            chk("wdata", mem_wdata[d], exp_wdata(wd, addr[1:0]));
          end
        end
      end
      if (resp_valid[d]) begin
        if (rv_cyc == 0) rv_cyc = c;
        chk("rdy_busy", 32'(req_ready[d]), 32'd0);
        if (c - rv_cyc < stall) begin
          resp_ready[d] = 1'b0;
          chk("stall_rdata", resp_rdata[d], sb_q[0].rdata);
          chk("stall_err", 32'(resp_err[d]), 32'(sb_q[0].err));
          chk("stall_mv", 32'(mem_valid[d]), 32'd0);
          if (chain) begin
            req_valid[d] = 1'b1; req_wen[d] = 1'b0; req_addr[d] = 32'h8000_0010;
            req_size[d] = 2'd2; req_signed[d] = 1'b0; req_wdata[d] = 32'h0;
          end
        end else begin
          resp_ready[d] = 1'b1;
          e = sb_q.pop_front();
          chk("resp_rdata", resp_rdata[d], e.rdata);
          chk("resp_err", 32'(resp_err[d]), 32'(e.err));
          done = 1'b1;
        end
      end
    end
    chk("resp_seen", 32'(done), 32'd1);
    chk("mv_cycles", 32'(nmv), err ? 32'd0 : 32'(lat));
    chk("wen_pulses", 32'(nwen), 32'(wen && !err));
    chk("rv_cycle", 32'(rv_cyc), err ? 32'd1 : 32'(lat + 1));
    if (!err) chk("mv_start", 32'(mv_first), 32'd1);
    @(negedge clk);
    chk("rdy_back", 32'(req_ready[d]), 32'd1);
    chk("rv_clear", 32'(resp_valid[d]), 32'd0);
  endtask

  // Store on instance 1 with reset landing in its second ACCESS cycle.
  task automatic rst_mid();
    int nwen;
    nwen = 0;
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
    req_wdata[1] = 32'h1122_3344; req_size[1] = 2'd2; req_signed[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rm_mv1", 32'(mem_valid[1]), 32'd1);
    if (mem_wen[1]) nwen++;
    @(negedge clk);
    chk("rm_mv2", 32'(mem_valid[1]), 32'd1);
    if (mem_wen[1]) nwen++;
    rst = 1'b1;
    @(negedge clk);
    if (mem_wen[1]) nwen++;
    chk("rm_wen_once", 32'(nwen), 32'd1);
    chk_reset(1, "rm");
    rst = 1'b0;
    @(negedge clk);
    chk_reset(1, "rm_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      req_size[d] = 2'd0; req_signed[d] = 1'b0; resp_ready[d] = 1'b1; mem_rdata[d] = 32'h0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    rst = 1'b0;

    do_req(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h8012_3456, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h8012_3456, 0, 1'b0, 1'b0);
    do_req(0, 1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'hABCD_0000, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 32'h5555_5555, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 32'h5555_5555, 0, 1'b0, 1'b0);
    do_req(0, 1'b1, 32'h8000_0001, 32'hFFFF, 2'd1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_req(0, 1'b1, 32'h8000_0001, 32'h0000_00A5, 2'd0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    do_req(0, 1'b0, 32'hFFFF_FFFE, 32'h0, 2'd1, 1'b0, 32'h8765_4321, 0, 1'b0, 1'b0);

    do_req(1, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'h0BAD_C0DE, 5, 1'b0, 1'b1);
    do_req(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 32'h1357_9BDF, 0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      a  = {16'h8000, a[15:0]};
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      rd = $urandom;
      do_req(1, 1'($urandom_range(0, 1)), a, wd, sz, 1'($urandom_range(0, 1)), rd,
             $urandom_range(0, 2), 1'b0, 1'b0);
    end

    rst_mid();
    do_req(1, 1'b0, 32'h8000_0005, 32'h0, 2'd0, 1'b1, 32'h0000_F000, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
